// File: rtl/sys_array_pkg.sv
// -----------------------------------------------------------------------------
// sys_array_pkg
// Shared types and constants for the systolic-array input feeder:
//   - feeder_state_e : control FSM states (IDLE / LOAD / DRAIN)
//   - len_t          : 16-bit column-count type used for the array length
//   - DEF_*          : default parameter values for the feeder
//   - clamp_len()    : maps a requested column count onto 1..max_len
// -----------------------------------------------------------------------------
package sys_array_pkg;

    localparam int unsigned DEF_DATA_WIDTH  = 8;
    localparam int unsigned DEF_ARRAY_MAX_W = 10;
    localparam int unsigned DEF_ARRAY_MAX_L = 10;
    localparam int unsigned LEN_WIDTH       = 16;

    typedef logic [LEN_WIDTH-1:0] len_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_LOAD  = 2'b01,
        ST_DRAIN = 2'b10
    } feeder_state_e;

    // A zero request still feeds one lane; anything wider than the array
    // is truncated to the physical lane count.
    function automatic len_t clamp_len(input len_t req, input len_t max_len);
        len_t res;
        if (req == 16'd0) begin
            res = 16'd1;
        end else if (req > max_len) begin
            res = max_len;
        end else begin
            res = req;
        end
        return res;
    endfunction

endpackage

// File: rtl/sys_array_skew_line.sv
// -----------------------------------------------------------------------------
// sys_array_skew_line
// Fixed-depth delay line for one feeder lane. Carries a data word together
// with its valid flag; a slot entered without valid carries zero data so the
// downstream array accumulates nothing from it.
// Ports:
//   clk_i   : clock (rising edge)
//   rst_ni  : asynchronous active-low reset, clears every stage
//   valid_i : element entering this lane is real
//   data_i  : element entering this lane
//   valid_o : valid flag after DEPTH cycles
//   data_o  : data after DEPTH cycles (zero when valid_o is 0)
// -----------------------------------------------------------------------------
module sys_array_skew_line #(
    parameter int unsigned DEPTH      = 1,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  valid_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic                  valid_o,
    output logic [DATA_WIDTH-1:0] data_o
);

    logic [DATA_WIDTH-1:0] data_q [0:DEPTH-1];
    logic [DEPTH-1:0]      valid_q;

    // Shift register: stage 0 takes the gated input, later stages shift down.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                data_q[i] <= {DATA_WIDTH{1'b0}};
            end
            valid_q <= {DEPTH{1'b0}};
        end else begin
            data_q[0]  <= valid_i ? data_i : {DATA_WIDTH{1'b0}};
            valid_q[0] <= valid_i;
            for (int i = 1; i < int'(DEPTH); i++) begin
                data_q[i]  <= data_q[i-1];
                valid_q[i] <= valid_q[i-1];
            end
        end
    end

    assign data_o  = data_q[DEPTH-1];
    assign valid_o = valid_q[DEPTH-1];

endmodule

// File: rtl/sys_array_feeder.sv
// -----------------------------------------------------------------------------
// sys_array_feeder
// Accepts unskewed input vectors (lane j = column j) and presents them to a
// systolic array with lane j delayed by j+1 cycles, so successive columns
// enter the array one cycle apart. Bubbles in the input stream become zero
// slots with feed_valid=0 on every lane, keeping the skew intact.
// Ports:
//   clk        : clock (rising edge)
//   reset_n    : asynchronous active-low reset, aborts any stream
//   start      : begin a stream (accepted only when idle)
//   array_w_l  : active column count, sampled on an accepted start
//   in_valid   : in_data / in_last valid
//   in_ready   : feeder accepts a vector this cycle (LOAD only)
//   in_last    : final vector of the stream
//   in_data    : unskewed input vector
//   feed_data  : skewed lanes to the array
//   feed_valid : per-lane real-element flag
//   busy       : stream in progress, including the final emission cycle
//   done       : one-cycle pulse once the last element has left the feeder
// -----------------------------------------------------------------------------
module sys_array_feeder
    import sys_array_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int unsigned ARRAY_MAX_W = DEF_ARRAY_MAX_W,
    parameter int unsigned ARRAY_MAX_L = DEF_ARRAY_MAX_L
) (
    input  logic                                    clk,
    input  logic                                    reset_n,
    input  logic                                    start,
    input  logic [15:0]                             array_w_l,
    input  logic                                    in_valid,
    output logic                                    in_ready,
    input  logic                                    in_last,
    input  logic [0:ARRAY_MAX_L-1][DATA_WIDTH-1:0]  in_data,
    output logic [0:ARRAY_MAX_L-1][DATA_WIDTH-1:0]  feed_data,
    output logic [0:ARRAY_MAX_L-1]                  feed_valid,
    output logic                                    busy,
    output logic                                    done
);

    localparam len_t MAX_LEN = len_t'(ARRAY_MAX_L);

    // The feeder never looks at the row count; the parameter exists so the
    // feeder shares the array's parameter set. A zero-row array is
    // meaningless, which this empty guard documents.
    if (ARRAY_MAX_W == 0) begin : g_zero_rows_unsupported
    end

    feeder_state_e          state_q, state_d;
    len_t                   l_eff_q, l_eff_d;
    len_t                   drain_cnt_q, drain_cnt_d;
    logic [0:ARRAY_MAX_L-1] lane_en_q, lane_en_d;
    logic                   in_ready_q, in_ready_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    len_t                   len_req_s;
    logic [0:ARRAY_MAX_L-1] lane_mask_s;
    logic                   start_ok_s;
    logic                   hs_s;

    // A handshake is only possible while in_ready_q is set, i.e. in LOAD.
    assign hs_s = in_valid & in_ready_q;

    // busy_q stays high for the last emission cycle after the FSM is back in
    // IDLE, so a new start is held off until the previous stream has fully
    // left the skew lines.
    assign start_ok_s = start & (state_q == ST_IDLE) & ~busy_q;

    // Effective length and lane-enable mask for a start seen this cycle.
    always_comb begin
        len_req_s   = clamp_len(array_w_l, MAX_LEN);
        lane_mask_s = {ARRAY_MAX_L{1'b0}};
        for (int j = 0; j < int'(ARRAY_MAX_L); j++) begin
            lane_mask_s[j] = (len_t'(j) < len_req_s);
        end
    end

    // Next-state and registered-output logic for the stream controller.
    always_comb begin
        state_d     = state_q;
        l_eff_d     = l_eff_q;
        drain_cnt_d = drain_cnt_q;
        lane_en_d   = lane_en_q;
        case (state_q)
            ST_IDLE: begin
                if (start_ok_s) begin
                    state_d   = ST_LOAD;
                    l_eff_d   = len_req_s;
                    lane_en_d = lane_mask_s;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (hs_s && in_last) begin
                    // Lane L-1 needs L-1 more edges after the last accept.
                    if (l_eff_q <= 16'd1) begin
                        state_d     = ST_IDLE;
                        drain_cnt_d = 16'd0;
                    end else begin
                        state_d     = ST_DRAIN;
                        drain_cnt_d = l_eff_q - 16'd1;
                    end
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_DRAIN: begin
                if (drain_cnt_q <= 16'd1) begin
                    state_d     = ST_IDLE;
                    drain_cnt_d = 16'd0;
                end else begin
                    state_d     = ST_DRAIN;
                    drain_cnt_d = drain_cnt_q - 16'd1;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                drain_cnt_d = 16'd0;
            end
        endcase

        in_ready_d = (state_d == ST_LOAD);
        busy_d     = (state_d != ST_IDLE) || (state_q != ST_IDLE);
        done_d     = (state_q == ST_IDLE) && busy_q;
    end

    // Controller state and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            l_eff_q     <= 16'd1;
            drain_cnt_q <= 16'd0;
            lane_en_q   <= {ARRAY_MAX_L{1'b0}};
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            l_eff_q     <= l_eff_d;
            drain_cnt_q <= drain_cnt_d;
            lane_en_q   <= lane_en_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign in_ready = in_ready_q;
    assign busy     = busy_q;
    assign done     = done_q;

    // One delay line per lane; lanes outside the active width never see a
    // valid input, so they stay at zero.
    for (genvar j = 0; j < int'(ARRAY_MAX_L); j++) begin : g_lane
        sys_array_skew_line #(
            .DEPTH      (j + 1),
            .DATA_WIDTH (DATA_WIDTH)
        ) u_line (
            .clk_i   (clk),
            .rst_ni  (reset_n),
            .valid_i (hs_s & lane_en_q[j]),
            .data_i  (in_data[j]),
            .valid_o (feed_valid[j]),
            .data_o  (feed_data[j])
        );
    end

endmodule

// File: tb/tb_sys_array_feeder.sv
// -----------------------------------------------------------------------------
// tb_sys_array_feeder
// Table-driven bench: each record is one clock cycle of inputs plus the
// outputs expected in that same cycle. Expected lane values are written by
// hand from the skew rule (vector accepted at edge c shows on lane j in the
// cycle after edge c+j). Real data values are never zero, so a lane is
// expected valid exactly when its expected data is non-zero.
// -----------------------------------------------------------------------------
module tb_sys_array_feeder;

    typedef logic [0:9][7:0] lanes_t;

    typedef struct {
        logic        start;
        logic [15:0] wl;
        logic        valid;
        logic        last;
        lanes_t      din;
        lanes_t      exp_d;
        logic        rdy;
        logic        bsy;
        logic        dn;
    } vec_t;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [15:0] array_w_l;
    logic        in_valid;
    logic        in_ready;
    logic        in_last;
    lanes_t      in_data;
    lanes_t      feed_data;
    logic [0:9]  feed_valid;
    logic        busy;
    logic        done;

    int n_checks;
    int n_fail;
    vec_t tbl[$];

    sys_array_feeder #(
        .DATA_WIDTH  (8),
        .ARRAY_MAX_W (10),
        .ARRAY_MAX_L (10)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .array_w_l  (array_w_l),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_last    (in_last),
        .in_data    (in_data),
        .feed_data  (feed_data),
        .feed_valid (feed_valid),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic lanes_t mk(input int a0 = 0, input int a1 = 0,
                                  input int a2 = 0, input int a3 = 0,
                                  input int a4 = 0, input int a5 = 0,
                                  input int a6 = 0, input int a7 = 0,
                                  input int a8 = 0, input int a9 = 0);
        lanes_t r;
        r[0] = a0[7:0]; r[1] = a1[7:0]; r[2] = a2[7:0]; r[3] = a3[7:0];
        r[4] = a4[7:0]; r[5] = a5[7:0]; r[6] = a6[7:0]; r[7] = a7[7:0];
        r[8] = a8[7:0]; r[9] = a9[7:0];
        return r;
    endfunction

    function automatic lanes_t one(input int lane, input int val);
        lanes_t r;
        r = '0;
        r[lane] = val[7:0];
        return r;
    endfunction

    function automatic logic [0:9] vmask(input lanes_t d);
        logic [0:9] m;
        for (int j = 0; j < 10; j++) m[j] = (d[j] != 8'd0);
        return m;
    endfunction

    task automatic chk(input string name, input int idx,
                       input logic [79:0] got, input logic [79:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s row %0d: actual %h required %h", name, idx, got, exp);
        end
    endtask

    task automatic row(input logic st, input int wl, input logic v, input logic l,
                       input lanes_t din, input lanes_t ed,
                       input logic rdy, input logic bsy, input logic dn);
        vec_t r;
        r.start = st; r.wl = wl[15:0]; r.valid = v; r.last = l;
        r.din = din; r.exp_d = ed; r.rdy = rdy; r.bsy = bsy; r.dn = dn;
        tbl.push_back(r);
    endtask

    // Apply every queued record: drive after the edge, check mid-cycle.
    task automatic run_table(input int base);
        for (int i = 0; i < tbl.size(); i++) begin
            start     = tbl[i].start;
            array_w_l = tbl[i].wl;
            in_valid  = tbl[i].valid;
            in_last   = tbl[i].last;
            in_data   = tbl[i].din;
            @(negedge clk);
            chk("feed_data",  base + i, 80'(feed_data), 80'(tbl[i].exp_d));
            chk("feed_valid", base + i, 80'(feed_valid), 80'(vmask(tbl[i].exp_d)));
            chk("in_ready",   base + i, 80'(in_ready), 80'(tbl[i].rdy));
            chk("busy",       base + i, 80'(busy), 80'(tbl[i].bsy));
            chk("done",       base + i, 80'(done), 80'(tbl[i].dn));
            @(posedge clk);
            #1;
        end
        tbl.delete();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_feed_data"},  0, 80'(feed_data), 80'd0);
        chk({tag, "_feed_valid"}, 0, 80'(feed_valid), 80'd0);
        chk({tag, "_in_ready"},   0, 80'(in_ready), 80'd0);
        chk({tag, "_busy"},       0, 80'(busy), 80'd0);
        chk({tag, "_done"},       0, 80'(done), 80'd0);
    endtask

    initial begin
        lanes_t z;
        lanes_t g;
        z = '0;
        g = mk(55, 55, 55, 55, 55, 55, 55, 55, 55, 55);
        n_checks  = 0;
        n_fail    = 0;
        reset_n   = 1'b0;
        start     = 1'b0;
        array_w_l = 16'd0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        in_data   = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // L=3, two vectors back to back
        row(1, 3, 0, 0, z, z, 0, 0, 0);
        row(0, 3, 1, 0, mk(1, 2, 3), z, 1, 1, 0);
        row(0, 3, 1, 1, mk(4, 5, 6), mk(1), 1, 1, 0);
        row(0, 3, 0, 0, z, mk(4, 2), 0, 1, 0);
        row(0, 3, 0, 0, z, mk(0, 5, 3), 0, 1, 0);
        row(0, 3, 0, 0, z, mk(0, 0, 6), 0, 1, 0);
        row(0, 3, 0, 0, z, z, 0, 0, 1);

        // L=4 with a one-cycle bubble; stray in_valid in IDLE and DRAIN
        row(1, 4, 1, 0, g, z, 0, 0, 0);
        row(0, 4, 1, 0, mk(11, 12, 13, 14), z, 1, 1, 0);
        row(0, 4, 0, 0, g, mk(11), 1, 1, 0);
        row(0, 4, 1, 1, mk(21, 22, 23, 24), mk(0, 12), 1, 1, 0);
        row(0, 4, 0, 0, z, mk(21, 0, 13), 0, 1, 0);
        row(0, 4, 1, 1, g, mk(0, 22, 0, 14), 0, 1, 0);
        row(0, 4, 0, 0, z, mk(0, 0, 23, 0), 0, 1, 0);
        row(0, 4, 0, 0, z, mk(0, 0, 0, 24), 0, 1, 0);
        row(0, 4, 0, 0, z, z, 0, 0, 1);

        // L=3, start with a new width during DRAIN and the tail cycle
        row(1, 3, 0, 0, z, z, 0, 0, 0);
        row(0, 3, 1, 1, mk(31, 32, 33), z, 1, 1, 0);
        row(1, 5, 0, 0, z, mk(31), 0, 1, 0);
        row(1, 5, 0, 0, z, mk(0, 32), 0, 1, 0);
        row(1, 5, 0, 0, z, mk(0, 0, 33), 0, 1, 0);
        row(0, 5, 0, 0, z, z, 0, 0, 1);
        // next stream uses L=5; width change while busy has no effect
        row(1, 5, 0, 0, z, z, 0, 0, 0);
        row(0, 2, 1, 1, mk(41, 42, 43, 44, 45, 46), z, 1, 1, 0);
        row(0, 2, 0, 0, z, mk(41), 0, 1, 0);
        row(0, 2, 0, 0, z, mk(0, 42), 0, 1, 0);
        row(0, 2, 0, 0, z, mk(0, 0, 43), 0, 1, 0);
        row(0, 2, 0, 0, z, mk(0, 0, 0, 44), 0, 1, 0);
        row(0, 2, 0, 0, z, mk(0, 0, 0, 0, 45), 0, 1, 0);
        row(0, 2, 0, 0, z, z, 0, 0, 1);

        // array_w_l=0 behaves as L=1
        row(1, 0, 0, 0, z, z, 0, 0, 0);
        row(0, 0, 1, 1, mk(51, 52, 53), z, 1, 1, 0);
        row(0, 0, 0, 0, z, mk(51), 0, 1, 0);
        row(0, 0, 0, 0, z, z, 0, 0, 1);

        // L=1 single vector {7}
        row(1, 1, 0, 0, z, z, 0, 0, 0);
        row(0, 1, 1, 1, mk(7), z, 1, 1, 0);
        row(0, 1, 0, 0, z, mk(7), 0, 1, 0);
        row(0, 1, 0, 0, z, z, 0, 0, 1);

        // array_w_l=15 behaves as L=10
        row(1, 15, 0, 0, z, z, 0, 0, 0);
        row(0, 15, 1, 1, mk(61, 62, 63, 64, 65, 66, 67, 68, 69, 70), z, 1, 1, 0);
        for (int j = 0; j < 10; j++) begin
            row(0, 15, 0, 0, z, one(j, 61 + j), 0, 1, 0);
        end
        row(0, 15, 0, 0, z, z, 0, 0, 1);
        row(0, 0, 0, 0, z, z, 0, 0, 0);

        run_table(0);

        // Reset in the middle of LOAD, with one vector already in flight
        start     = 1'b1;
        array_w_l = 16'd3;
        @(posedge clk);
        #1;
        start    = 1'b0;
        in_valid = 1'b1;
        in_data  = mk(81, 82, 83);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("preabort_lane0", 0, 80'(feed_data), 80'(mk(81)));
        #2;
        reset_n = 1'b0;
        #1;
        chk_all_zero("abort");
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Clean L=2 stream after the abort
        row(0, 2, 0, 0, z, z, 0, 0, 0);
        row(1, 2, 0, 0, z, z, 0, 0, 0);
        row(0, 2, 1, 0, mk(91, 92, 93), z, 1, 1, 0);
        row(0, 2, 1, 1, mk(94, 95, 96), mk(91), 1, 1, 0);
        row(0, 2, 0, 0, z, mk(94, 92), 0, 1, 0);
        row(0, 2, 0, 0, z, mk(0, 95), 0, 1, 0);
        row(0, 2, 0, 0, z, z, 0, 0, 1);
        row(0, 2, 0, 0, z, z, 0, 0, 0);
        run_table(1000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
